forwarding_hazard_unit: RTL and testbench

Parametrised successor to the pipeline forwarding logic. It resolves operand hazards for NUM_SRC source operands per instruction, using correct priority: EX/MEM first, then MEM/WB, then a registered WB-hold bypass. It also outputs the muxed operand data and detects load-use hazards. It sequences pipeline stalls for load-use bubbles and multi-cycle memory waits, and sits between the ID/EX register and the ALU input muxes.

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_src_select.sv | 65 ++++++
 rtl/forwarding_hazard_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding / hazard unit:
//   - forward-select codes driven on fwd_sel (one 2-bit code per source slot)
//   - hazard sequencer state encoding
//   - default architectural zero-register index
// -----------------------------------------------------------------------------
package fwd_pkg;

    // Forward-select codes (per source slot)
    localparam logic [1:0] FWD_REG    = 2'b00;  // register-file read data
    localparam logic [1:0] FWD_MEMWB  = 2'b01;  // MEM/WB write-back value
    localparam logic [1:0] FWD_EXMEM  = 2'b10;  // EX/MEM ALU result
    localparam logic [1:0] FWD_WBHOLD = 2'b11;  // value written back one cycle ago

    // Hazard sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    // Architectural zero register (reads as zero, writes discarded)
    localparam int ZERO_REG_DEFAULT = 31;

endpackage : fwd_pkg

// File: rtl/fwd_src_select.sv
// -----------------------------------------------------------------------------
// fwd_src_select
// Forwarding priority compare and data mux for one source operand.
// Priority: EX/MEM, then MEM/WB, then the WB-hold bypass, then the register file.
// Unused slots and reads of the zero register always take register-file data.
//
// Ports:
//   src_addr_i / src_used_i / src_data_i : operand index, valid, RF read data
//   ex_mem_fwd_ok_i, ex_mem_rd_i, ex_mem_result_i : EX/MEM producer (qualified)
//   mem_wb_fwd_ok_i, mem_wb_rd_i, mem_wb_data_i   : MEM/WB producer (qualified)
//   hold_valid_i, hold_rd_i, hold_data_i          : WB-hold producer
//   sel_o     : selected source code (fwd_pkg FWD_*)
//   operand_o : forwarded operand value
// -----------------------------------------------------------------------------
module fwd_src_select
    import fwd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int RA_W     = 5,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic [RA_W-1:0]   src_addr_i,
    input  logic              src_used_i,
    input  logic [DATA_W-1:0] src_data_i,
    input  logic              ex_mem_fwd_ok_i,
    input  logic [RA_W-1:0]   ex_mem_rd_i,
    input  logic [DATA_W-1:0] ex_mem_result_i,
    input  logic              mem_wb_fwd_ok_i,
    input  logic [RA_W-1:0]   mem_wb_rd_i,
    input  logic [DATA_W-1:0] mem_wb_data_i,
    input  logic              hold_valid_i,
    input  logic [RA_W-1:0]   hold_rd_i,
    input  logic [DATA_W-1:0] hold_data_i,
    output logic [1:0]        sel_o,
    output logic [DATA_W-1:0] operand_o
);

    localparam logic [RA_W-1:0] ZERO_IDX = RA_W'(ZERO_REG);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the if/else chain can leave it unassigned and infer a latch.
        sel_o = FWD_REG;
        if (src_used_i && (src_addr_i != ZERO_IDX)) begin
            if (ex_mem_fwd_ok_i && (ex_mem_rd_i == src_addr_i)) begin
                sel_o = FWD_EXMEM;
            end else if (mem_wb_fwd_ok_i && (mem_wb_rd_i == src_addr_i)) begin
                sel_o = FWD_MEMWB;
            end else if (hold_valid_i && (hold_rd_i == src_addr_i)) begin
                sel_o = FWD_WBHOLD;
            end
        end
    end

    always_comb begin
        operand_o = src_data_i;
        case (sel_o)
            FWD_EXMEM:  operand_o = ex_mem_result_i;
            FWD_MEMWB:  operand_o = mem_wb_data_i;
            FWD_WBHOLD: operand_o = hold_data_i;
            default:    operand_o = src_data_i;
        endcase
    end

endmodule : fwd_src_select

// File: rtl/forwarding_hazard_unit.sv
// -----------------------------------------------------------------------------
// forwarding_hazard_unit
// Operand forwarding for NUM_SRC sources of the EX instruction, load-use hazard
// detection for the ID instruction, and stall sequencing for load-use bubbles
// and multi-cycle data-memory accesses.
//
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   id_ex_src_addr/used/data      : EX-stage operand indices, valids, RF data
//   id_ex_memread, id_ex_rd       : EX instruction is a load / its destination
//   if_id_src_addr/used           : ID-stage operand indices and valids
//   ex_mem_regwrite/memread/memwrite, ex_mem_rd, ex_mem_result : EX/MEM stage
//   mem_wb_regwrite, mem_wb_rd, mem_wb_data                    : MEM/WB stage
//   mem_ready                     : data memory finishes the EX/MEM access now
//   fwd_sel, operand              : per-slot select code and forwarded value
//   stall_pc, stall_if_id         : hold PC and IF/ID
//   bubble_id_ex                  : inject a bubble into ID/EX
//   freeze                        : hold every pipeline register
//   stall_cycles                  : saturating count of stall_pc cycles
// -----------------------------------------------------------------------------
module forwarding_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int RA_W     = 5,
    parameter int NUM_SRC  = 3,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC*RA_W-1:0]   id_ex_src_addr,
    input  logic [NUM_SRC-1:0]        id_ex_src_used,
    input  logic [NUM_SRC*DATA_W-1:0] id_ex_src_data,
    input  logic                      id_ex_memread,
    input  logic [RA_W-1:0]           id_ex_rd,
    input  logic [NUM_SRC*RA_W-1:0]   if_id_src_addr,
    input  logic [NUM_SRC-1:0]        if_id_src_used,
    input  logic                      ex_mem_regwrite,
    input  logic                      ex_mem_memread,
    input  logic                      ex_mem_memwrite,
    input  logic [RA_W-1:0]           ex_mem_rd,
    input  logic [DATA_W-1:0]         ex_mem_result,
    input  logic                      mem_wb_regwrite,
    input  logic [RA_W-1:0]           mem_wb_rd,
    input  logic [DATA_W-1:0]         mem_wb_data,
    input  logic                      mem_ready,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0] operand,
    output logic                      stall_pc,
    output logic                      stall_if_id,
    output logic                      bubble_id_ex,
    output logic                      freeze,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam logic [RA_W-1:0] ZERO_IDX = RA_W'(ZERO_REG);

    // -------------------------------------------------------------------------
    // Producer qualification. A load in EX/MEM has no data yet, so it is never
    // a forwarding source; the load-use stall keeps consumers away from it.
    // -------------------------------------------------------------------------
    logic ex_mem_fwd_ok;
    logic mem_wb_fwd_ok;

    assign ex_mem_fwd_ok = ex_mem_regwrite && !ex_mem_memread && (ex_mem_rd != ZERO_IDX);
    assign mem_wb_fwd_ok = mem_wb_regwrite && (mem_wb_rd != ZERO_IDX);

    // -------------------------------------------------------------------------
    // WB-hold register: remembers last cycle's write-back so a reader issued
    // while the register file is still being written sees the new value.
    // -------------------------------------------------------------------------
    logic              hold_valid_q, hold_valid_d;
    logic [RA_W-1:0]   hold_rd_q,    hold_rd_d;
    logic [DATA_W-1:0] hold_data_q,  hold_data_d;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        if (!freeze) begin
            hold_valid_d = mem_wb_fwd_ok;
            hold_rd_d    = mem_wb_rd;
            hold_data_d  = mem_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its _d value from before the edge.
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-slot operand forwarding
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_select #(
            .DATA_W   (DATA_W),
            .RA_W     (RA_W),
            .ZERO_REG (ZERO_REG)
        ) u_sel (
            .src_addr_i      (id_ex_src_addr[g*RA_W +: RA_W]),
            .src_used_i      (id_ex_src_used[g]),
            .src_data_i      (id_ex_src_data[g*DATA_W +: DATA_W]),
            .ex_mem_fwd_ok_i (ex_mem_fwd_ok),
            .ex_mem_rd_i     (ex_mem_rd),
            .ex_mem_result_i (ex_mem_result),
            .mem_wb_fwd_ok_i (mem_wb_fwd_ok),
            .mem_wb_rd_i     (mem_wb_rd),
            .mem_wb_data_i   (mem_wb_data),
            .hold_valid_i    (hold_valid_q),
            .hold_rd_i       (hold_rd_q),
            .hold_data_i     (hold_data_q),
            .sel_o           (fwd_sel[g*2 +: 2]),
            .operand_o       (operand[g*DATA_W +: DATA_W])
        );
    end

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic lu_match;
    logic load_use;
    logic mem_wait;

    always_comb begin
        lu_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (if_id_src_used[i] && (if_id_src_addr[i*RA_W +: RA_W] == id_ex_rd)) begin
                lu_match = 1'b1;
            end
        end
    end

    assign load_use = id_ex_memread && (id_ex_rd != ZERO_IDX) && lu_match;
    assign mem_wait = (ex_mem_memread || ex_mem_memwrite) && !mem_ready;

    // -------------------------------------------------------------------------
    // Stall sequencer. A memory wait takes precedence over a load-use hazard:
    // freezing preserves ID/EX, so the hazard is simply seen again afterwards.
    // -------------------------------------------------------------------------
    hz_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                end else if (load_use) begin
                    state_d = LU_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            // The bubble already separates the load from its consumer, so the
            // hazard still visible this cycle must not stall a second time.
            LU_STALL: state_d = mem_wait ? MEM_WAIT : RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        freeze       = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    freeze      = 1'b1;
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                end else if (load_use) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
            LU_STALL: begin
                if (mem_wait) begin
                    freeze      = 1'b1;
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Stall-cycle performance counter (saturating)
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

    // -------------------------------------------------------------------------
    // Invariant: a load in EX/MEM never feeds a used EX operand, since the
    // load-use stall separates them by at least one cycle.
    // -------------------------------------------------------------------------
    logic ex_mem_load_hit;

    always_comb begin
        ex_mem_load_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_memread && (ex_mem_rd != ZERO_IDX) && id_ex_src_used[i] &&
                (id_ex_src_addr[i*RA_W +: RA_W] == ex_mem_rd)) begin
                ex_mem_load_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!ex_mem_load_hit);
        end
    end

endmodule : forwarding_hazard_unit

// File: tb/tb_forwarding_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_forwarding_hazard_unit
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the forwarding and stall rules.
// -----------------------------------------------------------------------------
module tb_forwarding_hazard_unit;

    localparam int DATA_W   = 64;
    localparam int RA_W     = 5;
    localparam int NUM_SRC  = 3;
    localparam int ZERO_REG = 31;
    localparam int CNT_W    = 4;   // small so saturation is reachable
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam logic [RA_W-1:0] ZR = RA_W'(ZERO_REG);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset_n;
    logic [NUM_SRC*RA_W-1:0]   id_ex_src_addr;
    logic [NUM_SRC-1:0]        id_ex_src_used;
    logic [NUM_SRC*DATA_W-1:0] id_ex_src_data;
    logic                      id_ex_memread;
    logic [RA_W-1:0]           id_ex_rd;
    logic [NUM_SRC*RA_W-1:0]   if_id_src_addr;
    logic [NUM_SRC-1:0]        if_id_src_used;
    logic                      ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite;
    logic [RA_W-1:0]           ex_mem_rd;
    logic [DATA_W-1:0]         ex_mem_result;
    logic                      mem_wb_regwrite;
    logic [RA_W-1:0]           mem_wb_rd;
    logic [DATA_W-1:0]         mem_wb_data;
    logic                      mem_ready;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [NUM_SRC*DATA_W-1:0] operand;
    logic                      stall_pc, stall_if_id, bubble_id_ex, freeze;
    logic [CNT_W-1:0]          stall_cycles;

    forwarding_hazard_unit #(
        .DATA_W(DATA_W), .RA_W(RA_W), .NUM_SRC(NUM_SRC),
        .ZERO_REG(ZERO_REG), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .id_ex_src_addr(id_ex_src_addr), .id_ex_src_used(id_ex_src_used),
        .id_ex_src_data(id_ex_src_data), .id_ex_memread(id_ex_memread),
        .id_ex_rd(id_ex_rd), .if_id_src_addr(if_id_src_addr),
        .if_id_src_used(if_id_src_used), .ex_mem_regwrite(ex_mem_regwrite),
        .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
        .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
        .mem_wb_data(mem_wb_data), .mem_ready(mem_ready),
        .fwd_sel(fwd_sel), .operand(operand), .stall_pc(stall_pc),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .freeze(freeze), .stall_cycles(stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic              m_hold_valid;
    logic [RA_W-1:0]   m_hold_rd;
    logic [DATA_W-1:0] m_hold_data;
    logic              m_lu_masked;   // previous cycle issued a load-use bubble
    int                m_cnt;

    // Expected control outputs for the current cycle
    logic e_freeze, e_stall, e_bubble;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest in-flight writer of the operand's register wins.
    function automatic logic [1:0] exp_sel(input int i);
        logic [RA_W-1:0] a;
        a = id_ex_src_addr[i*RA_W +: RA_W];
        if (!id_ex_src_used[i] || a == ZR) return 2'b00;
        if (ex_mem_regwrite && !ex_mem_memread && ex_mem_rd == a) return 2'b10;
        if (mem_wb_regwrite && mem_wb_rd == a) return 2'b01;
        if (m_hold_valid && m_hold_rd == a) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [DATA_W-1:0] exp_operand(input int i);
        case (exp_sel(i))
            2'b10:   return ex_mem_result;
            2'b01:   return mem_wb_data;
            2'b11:   return m_hold_data;
            default: return id_ex_src_data[i*DATA_W +: DATA_W];
        endcase
    endfunction

    function automatic logic exp_load_use();
        if (!id_ex_memread || id_ex_rd == ZR) return 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (if_id_src_used[i] && if_id_src_addr[i*RA_W +: RA_W] == id_ex_rd) return 1'b1;
        return 1'b0;
    endfunction

    // Compare every output against the model (called at the falling edge).
    task automatic sample();
        @(negedge clk);
        e_freeze = (ex_mem_memread || ex_mem_memwrite) && !mem_ready;
        e_bubble = !e_freeze && exp_load_use() && !m_lu_masked;
        e_stall  = e_freeze || e_bubble;
        for (int i = 0; i < NUM_SRC; i++) begin
            check($sformatf("fwd_sel%0d", i), 64'(fwd_sel[i*2 +: 2]), 64'(exp_sel(i)));
            check($sformatf("operand%0d", i), operand[i*DATA_W +: DATA_W], exp_operand(i));
        end
        check("freeze", 64'(freeze), 64'(e_freeze));
        check("stall_pc", 64'(stall_pc), 64'(e_stall));
        check("stall_if_id", 64'(stall_if_id), 64'(e_stall));
        check("bubble_id_ex", 64'(bubble_id_ex), 64'(e_bubble));
        check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
    endtask

    // Advance the model across the rising edge, then let inputs change.
    task automatic tick();
        if (!reset_n) begin
            m_hold_valid = 1'b0;
            m_hold_rd    = '0;
            m_hold_data  = '0;
            m_lu_masked  = 1'b0;
            m_cnt        = 0;
        end else begin
            if (e_stall && m_cnt < CNT_MAX) m_cnt++;
            if (!e_freeze) begin
                m_hold_valid = mem_wb_regwrite && mem_wb_rd != ZR;
                m_hold_rd    = mem_wb_rd;
                m_hold_data  = mem_wb_data;
            end
            m_lu_masked = e_bubble;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_ex_src_addr  = '0; id_ex_src_used = '0; id_ex_src_data = '0;
        id_ex_memread   = 1'b0; id_ex_rd = '0;
        if_id_src_addr  = '0; if_id_src_used = '0;
        ex_mem_regwrite = 1'b0; ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
        ex_mem_rd       = '0; ex_mem_result = '0;
        mem_wb_regwrite = 1'b0; mem_wb_rd = '0; mem_wb_data = '0;
        mem_ready       = 1'b1;
    endtask

    function automatic logic [RA_W-1:0] rand_reg();
        return ($urandom_range(0, 9) == 0) ? ZR : RA_W'($urandom_range(0, 7));
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < NUM_SRC; i++) begin
            id_ex_src_addr[i*RA_W +: RA_W] = rand_reg();
            if_id_src_addr[i*RA_W +: RA_W] = rand_reg();
            id_ex_src_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
        end
        id_ex_src_used  = NUM_SRC'($urandom);
        if_id_src_used  = NUM_SRC'($urandom);
        id_ex_memread   = ($urandom_range(0, 2) == 0);
        id_ex_rd        = rand_reg();
        ex_mem_regwrite = $urandom_range(0, 1) == 1;
        ex_mem_memread  = ($urandom_range(0, 4) == 0);
        ex_mem_memwrite = !ex_mem_memread && ($urandom_range(0, 4) == 0);
        ex_mem_rd       = rand_reg();
        ex_mem_result   = {$urandom, $urandom};
        mem_wb_regwrite = $urandom_range(0, 1) == 1;
        mem_wb_rd       = rand_reg();
        mem_wb_data     = {$urandom, $urandom};
        mem_ready       = ($urandom_range(0, 2) != 0);
        reset_n         = ($urandom_range(0, 59) != 0);
        // A real pipeline never lets a load in EX/MEM feed a used EX operand.
        if (ex_mem_memread)
            for (int i = 0; i < NUM_SRC; i++)
                if (id_ex_src_used[i] && id_ex_src_addr[i*RA_W +: RA_W] == ex_mem_rd)
                    ex_mem_rd = ZR;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        e_freeze = 1'b0; e_stall = 1'b0; e_bubble = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick();   // model picks up the reset (reset_n still low at this edge)
        reset_n = 1'b1;

        // Reset state with idle inputs
        sample();
        check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        check("rst_freeze", 64'(freeze), 64'd0);
        tick();

        // EX/MEM beats MEM/WB for the same register
        idle();
        id_ex_src_addr[0 +: RA_W] = 5'd3; id_ex_src_used[0] = 1'b1;
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd3; ex_mem_result = 64'hAA;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 64'hBB;
        sample();
        check("prio_sel0", 64'(fwd_sel[1:0]), 64'b10);
        check("prio_op0", operand[DATA_W-1:0], 64'hAA);
        tick();

        // Zero register is never forwarded
        idle();
        mem_wb_regwrite = 1'b1; mem_wb_rd = ZR; mem_wb_data = 64'h55;
        id_ex_src_addr[RA_W +: RA_W] = ZR; id_ex_src_used[1] = 1'b1;
        id_ex_src_data[DATA_W +: DATA_W] = 64'h1111;
        sample();
        check("zero_sel1", 64'(fwd_sel[3:2]), 64'b00);
        check("zero_op1", operand[DATA_W +: DATA_W], 64'h1111);
        tick();

        // Load-use: one bubble, then masked
        idle();
        id_ex_memread = 1'b1; id_ex_rd = 5'd5;
        if_id_src_addr[RA_W +: RA_W] = 5'd5; if_id_src_used[1] = 1'b1;
        sample();
        check("lu_stall_pc", 64'(stall_pc), 64'd1);
        check("lu_bubble", 64'(bubble_id_ex), 64'd1);
        tick();
        sample();
        check("lu_after_stall_pc", 64'(stall_pc), 64'd0);
        check("lu_after_bubble", 64'(bubble_id_ex), 64'd0);
        check("lu_stall_cycles", 64'(stall_cycles), 64'd1);
        tick();

        // Store waits 3 cycles; hold register must keep X12 meanwhile
        idle();
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd12; mem_wb_data = 64'hC0FFEE;
        sample(); tick();
        idle();
        ex_mem_memwrite = 1'b1; mem_ready = 1'b0;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd13; mem_wb_data = 64'hDEAD;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("mw_freeze_c%0d", c), 64'(freeze), 64'd1);
            tick();
        end
        mem_ready = 1'b1;
        id_ex_src_addr[0 +: RA_W] = 5'd12; id_ex_src_used[0] = 1'b1;
        sample();
        check("mw_release_freeze", 64'(freeze), 64'd0);
        check("mw_hold_sel0", 64'(fwd_sel[1:0]), 64'b11);
        check("mw_hold_op0", operand[DATA_W-1:0], 64'hC0FFEE);
        check("mw_stall_cycles", 64'(stall_cycles), 64'd4);
        tick();

        // WB-hold bypass one cycle after write-back
        idle();
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd7; mem_wb_data = 64'h1234;
        sample(); tick();
        idle();
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd8;
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd9;
        id_ex_src_addr[2*RA_W +: RA_W] = 5'd7; id_ex_src_used[2] = 1'b1;
        sample();
        check("hold_sel2", 64'(fwd_sel[5:4]), 64'b11);
        check("hold_op2", operand[2*DATA_W +: DATA_W], 64'h1234);
        tick();

        // Counter saturation
        idle();
        ex_mem_memread = 1'b1; ex_mem_rd = ZR; mem_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            sample(); tick();
        end
        sample();
        check("sat_stall_cycles", 64'(stall_cycles), 64'(CNT_MAX));
        tick();

        // Reset during MEM_WAIT abandons the stall and clears the hold
        idle();
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd20; mem_wb_data = 64'hABC;
        sample(); tick();
        idle();
        ex_mem_memread = 1'b1; ex_mem_rd = ZR; mem_ready = 1'b0;
        sample();
        check("rstmw_freeze", 64'(freeze), 64'd1);
        tick();
        reset_n = 1'b0;
        sample(); tick();
        reset_n = 1'b1;
        mem_ready = 1'b1;
        id_ex_src_addr[0 +: RA_W] = 5'd20; id_ex_src_used[0] = 1'b1;
        sample();
        check("rstmw_freeze_after", 64'(freeze), 64'd0);
        check("rstmw_stall_cycles", 64'(stall_cycles), 64'd0);
        check("rstmw_hold_cleared", 64'(fwd_sel[1:0]), 64'b00);
        tick();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            randomize_inputs();
            sample();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_forwarding_hazard_unit
